hilo_mac_unit: RTL and testbench



---
 rtl/hilo_pkg.sv | 38 +++
 rtl/hilo_seq_mult.sv | 42 ++++
 rtl/hilo_mac_unit.sv | 184 ++++++++++++++++++
 tb/tb_hilo_mac_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply-accumulate unit: op codes, FSM
// encoding, the latched request payload and op classification helpers.
package hilo_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_MULTU = 6'd1;
  localparam logic [OP_W-1:0] OP_MULT  = 6'd2;
  localparam logic [OP_W-1:0] OP_MTHI  = 6'd3;
  localparam logic [OP_W-1:0] OP_MTLO  = 6'd4;
  localparam logic [OP_W-1:0] OP_MADDU = 6'd28;
  localparam logic [OP_W-1:0] OP_MADD  = 6'd29;
  localparam logic [OP_W-1:0] OP_MSUBU = 6'd30;
  localparam logic [OP_W-1:0] OP_MSUB  = 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2
  } hiloState_t;

  // Request captured at start: operation and sign of the final product
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic            neg;
  } mulReq_t;

  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op == OP_MULTU) || (op == OP_MULT)  ||
           (op == OP_MADDU) || (op == OP_MADD)  ||
           (op == OP_MSUBU) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_seq_mult.sv
// Unsigned WIDTH x WIDTH radix-2 shift-add multiplier; one step per cycle,
// product valid after WIDTH steps following a load.
module hilo_seq_mult
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               step,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH-1:0] mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH:0]   partial;

  // Upper half plus multiplicand when the current multiplier bit is set
  always_comb begin
    partial = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand <= '0;
      acc   <= '0;
    end else if (load) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (step) begin
      acc <= {partial, acc[WIDTH-1:1]};
    end
  end

  assign product = acc;

endmodule

// File: rtl/hilo_mac_unit.sv
// HI/LO multiply-accumulate unit with an iterative multiplier core.
// Optional macro HILO_OVF_EN adds the sticky acc_ovf accumulate-overflow flag.
module hilo_mac_unit
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
`ifdef HILO_OVF_EN
  ,
  output logic             acc_ovf
`endif
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  hiloState_t       state, stateNext;
  mulReq_t          req, reqNext;
  logic [CNT_W-1:0] stepCnt, stepCntNext;
  logic             busyNext, doneNext;
  logic             loadMul, stepMul;
  logic             negA, negB;
  logic [WIDTH-1:0] magA, magB;
  logic [PW-1:0]    mulProduct, signedP;
  logic [PW-1:0]    hiLo, hiLoNext;
  logic [PW-1:0]    accSum, accDiff;
`ifdef HILO_OVF_EN
  logic             ovfNext;
  logic [PW:0]      addWide, subWide;
  logic             carryOut, borrowOut, sOvfAdd, sOvfSub;
`endif

  assign hiLo = {hi_out, lo_out};

  // Operand magnitudes; the two's-complement negation of the most-negative
  // value is exactly 2^(WIDTH-1) when read as unsigned
  always_comb begin
    negA = is_signed_op(op) && src_a[WIDTH-1];
    negB = is_signed_op(op) && src_b[WIDTH-1];
    magA = negA ? (~src_a + WIDTH'(1)) : src_a;
    magB = negB ? (~src_b + WIDTH'(1)) : src_b;
  end

  hilo_seq_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk    (clk),
    .rst    (rst),
    .load   (loadMul),
    .a      (magA),
    .b      (magB),
    .step   (stepMul),
    .product(mulProduct)
  );

  // Signed product and accumulate candidates, all mod 2^(2*WIDTH)
  always_comb begin
    signedP = req.neg ? (~mulProduct + PW'(1)) : mulProduct;
`ifdef HILO_OVF_EN
    addWide   = {1'b0, hiLo} + {1'b0, signedP};
    subWide   = {1'b0, hiLo} - {1'b0, signedP};
    accSum    = addWide[PW-1:0];
    accDiff   = subWide[PW-1:0];
    carryOut  = addWide[PW];
    borrowOut = subWide[PW];
    sOvfAdd   = (hiLo[PW-1] == signedP[PW-1]) && (accSum[PW-1] != hiLo[PW-1]);
    sOvfSub   = (hiLo[PW-1] != signedP[PW-1]) && (accDiff[PW-1] != hiLo[PW-1]);
`else
    accSum  = hiLo + signedP;
    accDiff = hiLo - signedP;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext   = state;
    reqNext     = req;
    stepCntNext = stepCnt;
    busyNext    = 1'b0;
    doneNext    = 1'b0;
    hiLoNext    = hiLo;
    loadMul     = 1'b0;
    stepMul     = 1'b0;
`ifdef HILO_OVF_EN
    ovfNext     = acc_ovf;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_mul_op(op)) begin
            stateNext   = ST_MUL;
            busyNext    = 1'b1;
            loadMul     = 1'b1;
            reqNext.op  = op;
            reqNext.neg = is_signed_op(op) && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            stepCntNext = '0;
          end else if (op == OP_MTHI) begin
            hiLoNext[PW-1:WIDTH] = src_a;
            doneNext             = 1'b1;
`ifdef HILO_OVF_EN
            ovfNext              = 1'b0;
`endif
          end else if (op == OP_MTLO) begin
            hiLoNext[WIDTH-1:0] = src_a;
            doneNext            = 1'b1;
`ifdef HILO_OVF_EN
            ovfNext             = 1'b0;
`endif
          end
        end
      end
      ST_MUL: begin
        busyNext    = 1'b1;
        stepMul     = 1'b1;
        stepCntNext = stepCnt + CNT_W'(1);
        if (stepCnt == CNT_W'(WIDTH - 1)) begin
          stateNext = ST_ACC;
        end
      end
      ST_ACC: begin
        stateNext = ST_IDLE;
        doneNext  = 1'b1;
        case (req.op)
          OP_MADDU, OP_MADD: hiLoNext = accSum;
          OP_MSUBU, OP_MSUB: hiLoNext = accDiff;
          default:           hiLoNext = signedP;
        endcase
`ifdef HILO_OVF_EN
        case (req.op)
          OP_MADDU: ovfNext = acc_ovf | carryOut;
          OP_MSUBU: ovfNext = acc_ovf | borrowOut;
          OP_MADD:  ovfNext = acc_ovf | sOvfAdd;
          OP_MSUB:  ovfNext = acc_ovf | sOvfSub;
          default:  ovfNext = 1'b0;
        endcase
`endif
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Datapath and handshake registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req     <= '0;
      stepCnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
`ifdef HILO_OVF_EN
      acc_ovf <= 1'b0;
`endif
    end else begin
      req     <= reqNext;
      stepCnt <= stepCntNext;
      busy    <= busyNext;
      done    <= doneNext;
      hi_out  <= hiLoNext[PW-1:WIDTH];
      lo_out  <= hiLoNext[WIDTH-1:0];
`ifdef HILO_OVF_EN
      acc_ovf <= ovfNext;
`endif
    end
  end

endmodule

// File: tb/tb_hilo_mac_unit.sv
// Self-checking bench for hilo_mac_unit (WIDTH=32): cycle-level reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_hilo_mac_unit;

  localparam logic [5:0] MULTU = 6'd1;
  localparam logic [5:0] MULT  = 6'd2;
  localparam logic [5:0] MTHI  = 6'd3;
  localparam logic [5:0] MTLO  = 6'd4;
  localparam logic [5:0] MADDU = 6'd28;
  localparam logic [5:0] MADD  = 6'd29;
  localparam logic [5:0] MSUBU = 6'd30;
  localparam logic [5:0] MSUB  = 6'd31;

  logic        clk, rst, start;
  logic [5:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;
`ifdef HILO_OVF_EN
  logic        acc_ovf;
`endif

  hilo_mac_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi_out(hi_out),
    .lo_out(lo_out)
`ifdef HILO_OVF_EN
    ,
    .acc_ovf(acc_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;
  int doneCnt = 0;
  int busyCnt = 0;
  logic checkEn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: arithmetic on 64-bit values straight from the op definitions
  function automatic logic [63:0] mdlProduct(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb;
    if (o == MULT || o == MADD || o == MSUB) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'b0, a};
      sb = {32'b0, b};
    end
    return sa * sb;
  endfunction

  function automatic logic [63:0] mdlResult(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                                            input logic [63:0] acc);
    logic [63:0] p;
    p = mdlProduct(o, a, b);
    case (o)
      MADDU, MADD: return acc + p;
      MSUBU, MSUB: return acc - p;
      default:     return p;
    endcase
  endfunction

`ifdef HILO_OVF_EN
  function automatic logic mdlOvf(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [63:0] acc, input logic old);
    logic [63:0] p;
    logic [64:0] u;
    logic [65:0] s;
    p = mdlProduct(o, a, b);
    case (o)
      MADDU: begin u = {1'b0, acc} + {1'b0, p}; return old | u[64]; end
      MSUBU: return old | (acc < p);
      MADD:  begin s = {{2{acc[63]}}, acc} + {{2{p[63]}}, p}; return old | (s[64] != s[63]); end
      MSUB:  begin s = {{2{acc[63]}}, acc} - {{2{p[63]}}, p}; return old | (s[64] != s[63]); end
      default: return 1'b0;
    endcase
  endfunction
  logic mOvf, pOvf;
`endif

  logic [31:0] mHi, mLo;
  logic        mBusy, mDone;
  logic [63:0] pend;
  int          mCnt;

  // Model: a multiply-class op occupies 33 cycles of busy, then lands with done
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mHi <= '0; mLo <= '0; mBusy <= 1'b0; mDone <= 1'b0; mCnt <= 0; pend <= '0;
`ifdef HILO_OVF_EN
      mOvf <= 1'b0; pOvf <= 1'b0;
`endif
    end else begin
      mDone <= 1'b0;
      if (mCnt != 0) begin
        mCnt <= mCnt - 1;
        if (mCnt == 1) begin
          mHi <= pend[63:32]; mLo <= pend[31:0]; mBusy <= 1'b0; mDone <= 1'b1;
`ifdef HILO_OVF_EN
          mOvf <= pOvf;
`endif
        end
      end else if (start) begin
        case (op)
          MULTU, MULT, MADDU, MADD, MSUBU, MSUB: begin
            mCnt <= 33; mBusy <= 1'b1;
            pend <= mdlResult(op, src_a, src_b, {mHi, mLo});
`ifdef HILO_OVF_EN
            pOvf <= mdlOvf(op, src_a, src_b, {mHi, mLo}, mOvf);
`endif
          end
          MTHI: begin
            mHi <= src_a; mDone <= 1'b1;
`ifdef HILO_OVF_EN
            mOvf <= 1'b0;
`endif
          end
          MTLO: begin
            mLo <= src_a; mDone <= 1'b1;
`ifdef HILO_OVF_EN
            mOvf <= 1'b0;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      check("cyc_busy", 64'(busy), 64'(mBusy));
      check("cyc_done", 64'(done), 64'(mDone));
      check("cyc_hi", 64'(hi_out), 64'(mHi));
      check("cyc_lo", 64'(lo_out), 64'(mLo));
`ifdef HILO_OVF_EN
      check("cyc_ovf", 64'(acc_ovf), 64'(mOvf));
`endif
    end
    if (done) doneCnt++;
    if (busy) busyCnt++;
  end

  // Called at posedge+1; returns in the first cycle where done is high
  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic runOp(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
    int n;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(n);
    lat = n + 1;
  endtask

  task automatic checkHiLo(input string name, input logic [31:0] eh, input logic [31:0] el);
    check({name, "_hi"}, 64'(hi_out), 64'(eh));
    check({name, "_lo"}, 64'(lo_out), 64'(el));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0;
    rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    #1 rst = 1'b0;
    checkEn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    checkHiLo("rst", 32'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Max unsigned product, latency and busy length
    busyCnt = 0;
    runOp(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("multu_latency", 64'(lat), 64'd34);
    check("multu_busy_len", 64'(busyCnt), 64'd33);
    checkHiLo("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

    // Issued in the done cycle of the previous op
    runOp(MULT, 32'hFFFF_FFFE, 32'd3, lat);
    checkHiLo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runOp(MULT, 32'h8000_0000, 32'h8000_0000, lat);
    checkHiLo("mult_minmin", 32'h4000_0000, 32'h0);

    runOp(MTHI, 32'h0, 32'h0, lat);
    check("mthi_latency", 64'(lat), 64'd1);
    runOp(MTLO, 32'hFFFF_FFFF, 32'h0, lat);
    checkHiLo("mtlo", 32'h0, 32'hFFFF_FFFF);
    runOp(MADDU, 32'd1, 32'd1, lat);
    checkHiLo("maddu_carry", 32'h1, 32'h0);

    runOp(MTHI, 32'h0, 32'h0, lat);
    runOp(MTLO, 32'h0, 32'h0, lat);
    runOp(MSUB, 32'd2, 32'd3, lat);
    checkHiLo("msub", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    runOp(MTHI, 32'h0, 32'h0, lat);
    runOp(MTLO, 32'd10, 32'h0, lat);
    runOp(MADD, 32'hFFFF_FFFD, 32'd4, lat);
    checkHiLo("madd_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp(MSUBU, 32'hFFFF_FFFF, 32'd2, lat);
    checkHiLo("msubu", 32'hFFFF_FFFE, 32'h0);
    runOp(MULT, 32'h8000_0000, 32'd1, lat);
    checkHiLo("mult_min_one", 32'hFFFF_FFFF, 32'h8000_0000);

    // Unknown op: no done, nothing written
    @(posedge clk); #1;
    d0 = doneCnt;
    start = 1'b1; op = 6'd7; src_a = 32'hDEAD_BEEF; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("badop_no_done", 64'(doneCnt - d0), 64'd0);
    check("badop_no_busy", 64'(busy), 64'd0);
    checkHiLo("badop", 32'hFFFF_FFFF, 32'h8000_0000);

    // Second start while busy is dropped
    d0 = doneCnt;
    start = 1'b1; op = MULTU; src_a = 32'd2; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; op = MULTU; src_a = 32'd5; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(lat);
    repeat (3) @(posedge clk);
    #1;
    check("busy_start_single_done", 64'(doneCnt - d0), 64'd1);
    checkHiLo("busy_start", 32'h0, 32'd6);

    // Asynchronous reset mid-multiply
    runOp(MTHI, 32'h1234_5678, 32'h0, lat);
    runOp(MTLO, 32'h1234_5678, 32'h0, lat);
    start = 1'b1; op = MADDU; src_a = 32'd3; src_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_abort_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    checkHiLo("abort", 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    runOp(MULTU, 32'd4, 32'd4, lat);
    checkHiLo("post_abort", 32'h0, 32'd16);

`ifdef HILO_OVF_EN
    runOp(MTHI, 32'hFFFF_FFFF, 32'h0, lat);
    runOp(MTLO, 32'hFFFF_FFFF, 32'h0, lat);
    runOp(MADDU, 32'd1, 32'd1, lat);
    checkHiLo("ovf_wrap", 32'h0, 32'h0);
    check("ovf_set", 64'(acc_ovf), 64'd1);
    runOp(MULTU, 32'd1, 32'd1, lat);
    check("ovf_clear", 64'(acc_ovf), 64'd0);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
